intra_residual_sad: RTL
=======================

# intra_residual_sad

Parametrised residual and SAD engine for the intra-prediction path. It streams one block of source pixels against NMODES candidate predictions, LANES pixels per beat, and emits full-precision signed residuals per mode every beat. Per-mode SAD accumulates over the block, and an optional sequential scan selects the lowest-cost mode. It sits between the intra predictors and the mode-decision/transform stages, replacing the fixed 16-pixel, 8-mode, wrap-around residual register stage.

## Interface
- NMODES, 8, number of candidate prediction modes
- PIX_W, 8, pixel bit width
- BLK, 16, pixels per block (4x4)
- LANES, 4, pixels per beat; BLK % LANES == 0 (elaboration error otherwise)
- clk  in  1  clock; rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- mb  in  [LANES][PIX_W]  source pixels, raster order
- pred  in  [NMODES][LANES][PIX_W]  prediction pixels per mode
- res_valid  out  1  residual beat valid (no backpressure)
- res_beat  out  $clog2(BLK/LANES)  beat index of res
- res  out  [NMODES][LANES] signed PIX_W+1  mb - pred
- sad_valid  out  1  block result valid
- sad_ready  in  1  result consumed when sad_valid && sad_ready
- sad  out  [NMODES][SAD_W]  per-mode SAD, SAD_W = PIX_W + $clog2(BLK)
- best_mode  out  $clog2(NMODES)  index of minimum SAD
- best_sad  out  SAD_W  minimum SAD

## Operation
- States: ACC, CMP, DONE. Reset enters ACC.
- ACC: in_ready = 1.
  - Per accepted beat: res[m][l] <= mb[l] - pred[m][l], computed in PIX_W+1 signed with no wrap (range -(2^PIX_W-1)..2^PIX_W-1).
  - Per accepted beat: sad[m] += |mb[l]-pred[m][l]| summed over lanes. beat_cnt increments.
  - On the final beat (beat_cnt == BLK/LANES-1): beat_cnt <= 0 and the next state is CMP.
- CMP: in_ready = 0. Scan index k = 0..NMODES-1, one mode per cycle.
  - If k == 0 or sad[k] < best_sad: best_sad <= sad[k], best_mode <= k.
  - Strict compare, so ties go to the lowest index.
  - After k == NMODES-1, go to DONE.
- DONE: sad_valid = 1, in_ready = 0. sad, best_mode and best_sad are held stable.
  - On sad_valid && sad_ready: clear accumulators and go to ACC.
- Beats may have gaps; in_valid low leaves all state unchanged.
- Mode index order (package enum): V, H, VL, VR, HU, HD, DDL, DDR. Extra modes beyond 8 are unnamed.

## Timing
- Reset values: in_ready 0 during reset and 1 the cycle after; res_valid 0, res 0, res_beat 0, sad_valid 0, sad 0, best_mode 0, best_sad 0, beat_cnt 0, state ACC.
- Residual latency: 1 cycle. res_valid is high in the cycle after each accepted beat, for one cycle.
- Result latency: sad_valid rises NMODES+1 cycles after the edge that accepts the last beat.
- New block: the first beat is accepted in the cycle after the sad handshake, giving a throughput bubble of NMODES+1 cycles plus consumer stall.
- Residuals from the last beat are emitted while in CMP.
- Reset mid-block: the partial block is discarded, and the next beat is treated as beat 0.
- Reset in DONE: the result is dropped without a handshake.
- No overflow is possible, since the maximum SAD is BLK*(2^PIX_W-1) < 2^SAD_W.

## Configuration
- INTRA_BEST_MODE_EN defined: CMP state and the comparator are built, as above.
- INTRA_BEST_MODE_EN undefined:
  - CMP is omitted; the final beat goes directly to DONE.
  - sad_valid rises 1 cycle after the last beat.
  - best_mode and best_sad are tied to 0.

## Structure
- Package intra_pkg holds:
  - intra_mode_e enum (V..DDR)
  - res_state_e enum (ACC, CMP, DONE)
  - default constants INTRA_NMODES = 8, INTRA_PIX_W = 8, INTRA_BLK = 16
  - function sad_width(pix_w, blk)
- Sub-module intra_res_lane: one pixel pair -> signed residual plus absolute difference. It is instantiated NMODES*LANES times, and the top keeps the FSM, counters, accumulators and scan.

## Test plan
Defaults apply: NMODES=8, PIX_W=8, BLK=16, LANES=4, macro defined.
- mb=100 all, pred[m]=100+m, 4 back-to-back beats -> res[m] = -m on each beat; sad[m] = 16*m; best_mode 0, best_sad 0; sad_valid 9 cycles after the last beat.
- mb=0, pred all 255 -> res = -255 (9'h101); sad = 4080 for every mode; best_mode 0.
- Modes 3 and 5 exact match, others off by 1 -> sad[3] = sad[5] = 0; best_mode 3 (tie to lowest).
- sad_ready held low 10 cycles in DONE -> outputs stable and in_ready 0; handshake -> ACC, next beat accepted the following cycle.
- Reset after 2 beats, then a full block with sad 16 per mode -> sad exactly 16, with no residue from the partial block.
- Random in_valid gaps between beats -> results identical to back-to-back; macro undefined -> sad_valid 1 cycle after the last beat, best_mode 0.

Source files
------------

// File: rtl/intra_residual_sad_pkg.sv
// Shared types and defaults for the intra residual / SAD engine.
// Build option: define INTRA_BEST_MODE_EN to build the lowest-cost mode scan.
package intra_pkg;

    localparam int INTRA_NMODES = 8;
    localparam int INTRA_PIX_W  = 8;
    localparam int INTRA_BLK    = 16;

    // Candidate prediction modes in scan order; modes past DDR are unnamed.
    typedef enum logic [2:0] {
        MODE_V   = 3'd0,
        MODE_H   = 3'd1,
        MODE_VL  = 3'd2,
        MODE_VR  = 3'd3,
        MODE_HU  = 3'd4,
        MODE_HD  = 3'd5,
        MODE_DDL = 3'd6,
        MODE_DDR = 3'd7
    } intra_mode_e;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } res_state_e;

    // Accumulator width that holds blk * (2^pix_w - 1) without overflow.
    function automatic int sad_width(input int pix_w, input int blk);
        return pix_w + $clog2(blk);
    endfunction

endpackage

// File: rtl/intra_residual_sad_lane.sv
// One pixel pair: full-precision signed residual and absolute difference.
module intra_res_lane
    import intra_pkg::*;
#(
    parameter int PIX_W = INTRA_PIX_W
) (
    input  logic [PIX_W-1:0] src,
    input  logic [PIX_W-1:0] prd,
    output logic [PIX_W:0]   res,
    output logic [PIX_W-1:0] absd
);

    // Widen by one bit so src - prd never wraps; the magnitude comes from the ordered subtraction.
    always_comb begin
        res = {1'b0, src} - {1'b0, prd};
        if (src >= prd) begin
            absd = src - prd;
        end else begin
            absd = prd - src;
        end
    end

endmodule

// File: rtl/intra_residual_sad.sv
// Residual and per-mode SAD engine for the intra-prediction path.
// Build option: INTRA_BEST_MODE_EN adds a sequential scan for the lowest-SAD mode;
// without it the block result is presented right after the last beat and
// best_mode / best_sad read as zero.
module intra_residual_sad
    import intra_pkg::*;
#(
    parameter  int NMODES = INTRA_NMODES,
    parameter  int PIX_W  = INTRA_PIX_W,
    parameter  int BLK    = INTRA_BLK,
    parameter  int LANES  = 4,
    localparam int BEATS  = BLK / LANES,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int MODE_W = (NMODES > 1) ? $clog2(NMODES) : 1,
    localparam int SAD_W  = sad_width(PIX_W, BLK)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [LANES-1:0][PIX_W-1:0]              mb,
    input  logic [NMODES-1:0][LANES-1:0][PIX_W-1:0]  pred,
    output logic                                     res_valid,
    output logic [BEAT_W-1:0]                        res_beat,
    output logic [NMODES-1:0][LANES-1:0][PIX_W:0]    res,
    output logic                                     sad_valid,
    input  logic                                     sad_ready,
    output logic [NMODES-1:0][SAD_W-1:0]             sad,
    output logic [MODE_W-1:0]                        best_mode,
    output logic [SAD_W-1:0]                         best_sad
);

    if (BLK % LANES != 0) begin : g_bad_lanes
        $error("intra_residual_sad: BLK must be a multiple of LANES");
    end

    res_state_e                             state_q, state_d;
    logic [BEAT_W-1:0]                      beat_cnt_q, beat_cnt_d;
    logic [NMODES-1:0][SAD_W-1:0]           sad_q, sad_d;
    logic [NMODES-1:0][LANES-1:0][PIX_W:0]  res_q, res_d;
    logic                                   res_valid_q, res_valid_d;
    logic [BEAT_W-1:0]                      res_beat_q, res_beat_d;
    logic                                   sad_valid_q, sad_valid_d;

    logic [NMODES-1:0][LANES-1:0][PIX_W:0]   lane_res_s;
    logic [NMODES-1:0][LANES-1:0][PIX_W-1:0] lane_abs_s;
    logic [NMODES-1:0][SAD_W-1:0]            beat_sad_s;
    logic                                    accept_s;

`ifdef INTRA_BEST_MODE_EN
    // One extra count past the last mode lets the final compare settle before the result is flagged.
    localparam int KW = $clog2(NMODES + 1);
    logic [KW-1:0]     scan_k_q, scan_k_d;
    logic [MODE_W-1:0] scan_idx_s;
    logic [MODE_W-1:0] best_mode_q, best_mode_d;
    logic [SAD_W-1:0]  best_sad_q, best_sad_d;

    assign scan_idx_s = scan_k_q[MODE_W-1:0];
`endif

    for (genvar m = 0; m < NMODES; m++) begin : g_mode
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            intra_res_lane #(
                .PIX_W (PIX_W)
            ) u_lane (
                .src  (mb[l]),
                .prd  (pred[m][l]),
                .res  (lane_res_s[m][l]),
                .absd (lane_abs_s[m][l])
            );
        end
    end

    // in_ready is decoded from the state register and forced low while reset is held.
    assign in_ready = (state_q == ACC) && !reset;
    assign accept_s = in_valid && in_ready;

    // Sum of absolute differences across the lanes of the current beat, per mode.
    always_comb begin
        beat_sad_s = '0;
        for (int m = 0; m < NMODES; m++) begin
            for (int l = 0; l < LANES; l++) begin
                beat_sad_s[m] = beat_sad_s[m] + SAD_W'(lane_abs_s[m][l]);
            end
        end
    end

    // Next-state logic: accumulate beats, optionally scan for the best mode, then hold until consumed.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        sad_d       = sad_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        res_beat_d  = res_beat_q;
        sad_valid_d = sad_valid_q;
`ifdef INTRA_BEST_MODE_EN
        scan_k_d    = scan_k_q;
        best_mode_d = best_mode_q;
        best_sad_d  = best_sad_q;
`endif
        case (state_q)
            ACC: begin
                sad_valid_d = 1'b0;
                if (accept_s) begin
                    res_valid_d = 1'b1;
                    res_beat_d  = beat_cnt_q;
                    res_d       = lane_res_s;
                    for (int m = 0; m < NMODES; m++) begin
                        sad_d[m] = sad_q[m] + beat_sad_s[m];
                    end
                    if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                        beat_cnt_d = '0;
`ifdef INTRA_BEST_MODE_EN
                        state_d    = CMP;
`else
                        state_d     = DONE;
                        sad_valid_d = 1'b1;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end else begin
                    res_valid_d = 1'b0;
                end
            end
`ifdef INTRA_BEST_MODE_EN
            CMP: begin
                if (scan_k_q != KW'(NMODES)) begin
                    if ((scan_k_q == KW'(0)) || (sad_q[scan_idx_s] < best_sad_q)) begin
                        best_sad_d  = sad_q[scan_idx_s];
                        best_mode_d = scan_idx_s;
                    end else begin
                        best_sad_d  = best_sad_q;
                    end
                    scan_k_d = scan_k_q + KW'(1);
                end else begin
                    scan_k_d    = '0;
                    state_d     = DONE;
                    sad_valid_d = 1'b1;
                end
            end
`endif
            DONE: begin
                sad_valid_d = 1'b1;
                if (sad_valid_q && sad_ready) begin
                    sad_d       = '0;
                    sad_valid_d = 1'b0;
                    state_d     = ACC;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = ACC;
                beat_cnt_d  = '0;
                sad_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACC;
            beat_cnt_q  <= '0;
            sad_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_beat_q  <= '0;
            sad_valid_q <= 1'b0;
`ifdef INTRA_BEST_MODE_EN
            scan_k_q    <= '0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            sad_q       <= sad_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_beat_q  <= res_beat_d;
            sad_valid_q <= sad_valid_d;
`ifdef INTRA_BEST_MODE_EN
            scan_k_q    <= scan_k_d;
            best_mode_q <= best_mode_d;
            best_sad_q  <= best_sad_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_beat  = res_beat_q;
    assign res       = res_q;
    assign sad_valid = sad_valid_q;
    assign sad       = sad_q;
`ifdef INTRA_BEST_MODE_EN
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;
`else
    assign best_mode = '0;
    assign best_sad  = '0;
`endif

endmodule
